// File: rtl/axi_rd_arbiter.sv
// Two-port arbiter for a single no-ID AXI read master: one outstanding transaction,
// the grant is held from AR issue through the RLAST handshake.
module axi_rd_arbiter #(
   parameter int ADDR_W = 64,
   parameter bit RR_EN  = 1'b1
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic [2*ADDR_W-1:0]   s_araddr,
   input  logic [15:0]           s_arlen,
   input  logic [5:0]            s_arsize,
   input  logic [3:0]            s_arburst,
   input  logic [1:0]            s_arvalid,
   output logic [1:0]            s_arready,
   output logic [1:0]            s_rvalid,
   input  logic [1:0]            s_rready,
   output logic [ADDR_W-1:0]     m_araddr,
   output logic [7:0]            m_arlen,
   output logic [2:0]            m_arsize,
   output logic [1:0]            m_arburst,
   output logic                  m_arvalid,
   input  logic                  m_arready,
   input  logic                  m_rvalid,
   input  logic                  m_rlast,
   output logic                  m_rready
);

   typedef enum logic [1:0] {ST_IDLE, ST_ADDR, ST_DATA} state_t;

   state_t r_st;
   state_t w_st_next;
   logic   r_gnt;
   logic   w_gnt_next;
   logic   r_last;
   logic   w_last_next;

   logic [ADDR_W-1:0] w_addr  [2];
   logic [7:0]        w_len   [2];
   logic [2:0]        w_size  [2];
   logic [1:0]        w_burst [2];

   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_port
         assign w_addr[gi]  = s_araddr[gi*ADDR_W +: ADDR_W];
         assign w_len[gi]   = s_arlen[gi*8 +: 8];
         assign w_size[gi]  = s_arsize[gi*3 +: 3];
         assign w_burst[gi] = s_arburst[gi*2 +: 2];
      end
   endgenerate

   // Payload always follows the current owner; it only matters while m_arvalid is high.
   assign m_araddr  = w_addr[r_gnt];
   assign m_arlen   = w_len[r_gnt];
   assign m_arsize  = w_size[r_gnt];
   assign m_arburst = w_burst[r_gnt];

   always_ff @(posedge clock) begin
      if (reset) begin
         r_st   <= ST_IDLE;
         r_gnt  <= 1'b0;
         r_last <= 1'b1;
      end else begin
         r_st   <= w_st_next;
         r_gnt  <= w_gnt_next;
         r_last <= w_last_next;
      end
   end

   always_comb begin
      w_st_next   = r_st;
      w_gnt_next  = r_gnt;
      w_last_next = r_last;
      case (r_st)
         ST_IDLE: begin
            if (|s_arvalid) begin
               w_st_next = ST_ADDR;
               if (s_arvalid == 2'b11)
                  w_gnt_next = RR_EN ? ~r_last : 1'b0;
               else
                  w_gnt_next = s_arvalid[1];
            end
         end
         ST_ADDR: begin
            // A requester withdrawing before the handshake releases the bus.
            if (!s_arvalid[r_gnt])
               w_st_next = ST_IDLE;
            else if (m_arready)
               w_st_next = ST_DATA;
         end
         ST_DATA: begin
            if (m_rvalid && s_rready[r_gnt] && m_rlast) begin
               w_st_next   = ST_IDLE;
               w_last_next = r_gnt;
            end
         end
         default: w_st_next = ST_IDLE;
      endcase
   end

   always_comb begin
      s_arready = 2'b00;
      s_rvalid  = 2'b00;
      m_arvalid = 1'b0;
      m_rready  = 1'b0;
      case (r_st)
         ST_ADDR: begin
            m_arvalid        = s_arvalid[r_gnt];
            s_arready[r_gnt] = m_arready;
         end
         ST_DATA: begin
            s_rvalid[r_gnt] = m_rvalid;
            m_rready        = s_rready[r_gnt];
         end
         default: ;
      endcase
   end

endmodule
